// File: rtl/stfq_rank_stage.sv
// stfq_rank_stage: Start-Time Fair Queueing rank computation in front of a register PIFO.
//
// Each accepted descriptor gets rank start = max(vtime, finish[flow]). The flow's finish tag then
// advances to start + inc, clamped to all-ones; a clamp sets the sticky sat flag. The rank and
// metadata are registered and presented with a one-cycle insert strobe. Virtual time follows the
// largest rank the PIFO has dequeued.
//
// Optional feature macro: STFQ_WEIGHT_EN. When defined, a per-flow 3-bit shift table divides the
// packet length, so inc = len >> shift[flow]. When undefined, inc = len and the cfg_* ports are
// ignored.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   pkt_valid_i/pkt_ready_o    descriptor handshake
//   pkt_flow_i/len_i/meta_i    descriptor fields
//   insert_o/rank_out_o/meta_out_o  PIFO insert strobe, rank and metadata
//   pifo_count_i               PIFO occupancy, used for flow control
//   deq_valid_i/deq_rank_i     PIFO dequeue report, advances virtual time
//   cfg_we_i/cfg_flow_i/cfg_shift_i  shift table write port
//   vtime_o                    current virtual time
//   sat_o                      sticky finish-tag saturation flag
module stfq_rank_stage #(
  parameter int unsigned NumFlows  = 16,
  parameter int unsigned FlowW     = 4,
  parameter int unsigned LenW      = 11,
  parameter int unsigned RankW     = 16,
  parameter int unsigned MetaW     = 12,
  parameter int unsigned PifoDepth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pkt_valid_i,
  output logic             pkt_ready_o,
  input  logic [FlowW-1:0] pkt_flow_i,
  input  logic [LenW-1:0]  pkt_len_i,
  input  logic [MetaW-1:0] pkt_meta_i,
  output logic             insert_o,
  output logic [RankW-1:0] rank_out_o,
  output logic [MetaW-1:0] meta_out_o,
  input  logic [4:0]       pifo_count_i,
  input  logic             deq_valid_i,
  input  logic [RankW-1:0] deq_rank_i,
  input  logic             cfg_we_i,
  input  logic [FlowW-1:0] cfg_flow_i,
  input  logic [2:0]       cfg_shift_i,
  output logic [RankW-1:0] vtime_o,
  output logic             sat_o
);

  localparam int unsigned IdxW = (NumFlows > 1) ? $clog2(NumFlows) : 1;
  localparam logic [5:0] DepthLimit = 6'(PifoDepth);

  logic [RankW-1:0] finish_q [NumFlows];
  logic             insert_q, insert_d;
  logic [RankW-1:0] rank_q, rank_d;
  logic [MetaW-1:0] meta_q, meta_d;
  logic [RankW-1:0] vtime_q, vtime_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [IdxW-1:0]  flow_idx;
  logic [RankW-1:0] tag_cur;
  logic [RankW-1:0] start;
  logic [RankW:0]   inc;
  logic [RankW:0]   sum;
  logic [RankW-1:0] tag_new;

  // Wraps out-of-range IDs when the table is not a power of two deep.
  assign flow_idx = IdxW'(32'(pkt_flow_i) % NumFlows);

  // Occupancy plus the insert already in flight must leave room for one more entry.
  assign pkt_ready_o = (({1'b0, pifo_count_i} + 6'(insert_q)) < DepthLimit);
  assign accept      = pkt_valid_i & pkt_ready_o;

  assign tag_cur = finish_q[flow_idx];
  assign start   = (tag_cur > vtime_q) ? tag_cur : vtime_q;

`ifdef STFQ_WEIGHT_EN
  logic [2:0]      shift_q [NumFlows];
  logic [IdxW-1:0] cfg_idx;

  assign cfg_idx = IdxW'(32'(cfg_flow_i) % NumFlows);
  assign inc     = (RankW+1)'(pkt_len_i >> shift_q[flow_idx]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumFlows); i++) shift_q[i] <= '0;
    end else if (cfg_we_i) begin
      shift_q[cfg_idx] <= cfg_shift_i;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{cfg_we_i, cfg_flow_i, cfg_shift_i};
  assign inc        = (RankW+1)'(pkt_len_i);
`endif

  // One extra bit catches overflow; an overflowing tag clamps to all-ones.
  assign sum     = {1'b0, start} + inc;
  assign tag_new = sum[RankW] ? '1 : sum[RankW-1:0];

  always_comb begin
    insert_d = accept;
    rank_d   = rank_q;
    meta_d   = meta_q;
    sat_d    = sat_q;
    vtime_d  = vtime_q;
    if (accept) begin
      rank_d = start;
      meta_d = pkt_meta_i;
      if (sum[RankW]) sat_d = 1'b1;
    end
    // Rank above uses the pre-update vtime even when a dequeue lands in the same cycle.
    if (deq_valid_i && (deq_rank_i > vtime_q)) vtime_d = deq_rank_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      insert_q <= 1'b0;
      rank_q   <= '0;
      meta_q   <= '0;
      vtime_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      insert_q <= insert_d;
      rank_q   <= rank_d;
      meta_q   <= meta_d;
      vtime_q  <= vtime_d;
      sat_q    <= sat_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumFlows); i++) finish_q[i] <= '0;
    end else if (accept) begin
      finish_q[flow_idx] <= tag_new;
    end
  end

  assign insert_o   = insert_q;
  assign rank_out_o = rank_q;
  assign meta_out_o = meta_q;
  assign vtime_o    = vtime_q;
  assign sat_o      = sat_q;

endmodule

// File: doc/stfq_rank_stage.md
# stfq_rank_stage

Upstream rank-computation stage for the 16-entry register PIFO. Accepts packet descriptors (flow ID, length, metadata) and computes a Start-Time Fair Queueing rank per packet using a per-flow finish-tag table and a virtual-time register. Drives the PIFO's insert/rank/meta inputs directly. Uses the PIFO's entry count for flow control and its dequeued rank to advance virtual time.

## Interface
- NUM_FLOWS, 16, number of flows; the finish-tag table depth
- FLOW_W, 4, flow ID width (log2 NUM_FLOWS)
- LEN_W, 11, packet length width in bytes
- RANK_W, 16, rank/tag width
- META_W, 12, metadata width
- PIFO_DEPTH, 16, PIFO capacity in entries
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- pkt_valid  in  1  descriptor present
- pkt_ready  out  1  stage accepts descriptor this cycle
- pkt_flow  in  FLOW_W  flow ID
- pkt_len  in  LEN_W  packet length
- pkt_meta  in  META_W  opaque metadata, passed through
- insert  out  1  one-cycle PIFO insert strobe
- rank_out  out  RANK_W  rank to PIFO rank_in
- meta_out  out  META_W  metadata to PIFO meta_in
- pifo_count  in  5  PIFO num_entries
- deq_valid  in  1  PIFO removed an entry this cycle
- deq_rank  in  RANK_W  rank of removed entry
- cfg_we  in  1  weight table write strobe
- cfg_flow  in  FLOW_W  weight table index
- cfg_shift  in  3  weight shift value
- vtime  out  RANK_W  current virtual time
- sat  out  1  sticky: a finish tag saturated

## Operation
- Accept when pkt_valid & pkt_ready. Then:
  - start = max(vtime, finish[pkt_flow])
  - finish[pkt_flow] <= start + inc
  - inc = pkt_len, or pkt_len >> shift[pkt_flow] with weighting (see Configuration)
- Sum is computed at RANK_W+1 bits. If it exceeds 2^RANK_W-1, the finish tag saturates to 2^RANK_W-1 and sat sets. sat clears only on reset.
- Registered output on the edge after acceptance: insert=1, rank_out=start, meta_out=pkt_meta.
- insert is low on any cycle without an acceptance in the prior cycle. rank_out/meta_out hold their last values when insert=0.
- Flow control: pkt_ready = (pifo_count + insert) < PIFO_DEPTH, computed at 6 bits.
  - This accounts for the in-flight insert, so the PIFO is never written while full.
  - pkt_ready does not depend on pkt_valid.
- Virtual time: on deq_valid, vtime <= max(vtime, deq_rank). vtime is monotonic non-decreasing.
- Simultaneous accept and deq_valid in the same cycle: rank uses the pre-update vtime; both updates commit on the same edge.
- Back-to-back descriptors on the same flow: the second uses the finish tag written by the first. The table write is visible next cycle, so no hazard exists at one descriptor per cycle.
- Out-of-range flow IDs are impossible when NUM_FLOWS = 2^FLOW_W. Otherwise, the index wraps modulo NUM_FLOWS.

## Timing
- Latency: descriptor accepted at edge N → insert high during cycle N+1, sampled by the PIFO at edge N+1.
- Throughput: one descriptor per cycle while pkt_ready=1.
- pkt_ready is combinational from pifo_count and the insert register.
- vtime updates one edge after deq_valid.
- Reset (rst=0, asynchronous): insert=0, rank_out=0, meta_out=0, vtime=0, sat=0, all finish tags=0, all shifts=0.
  - pkt_ready evaluates to 1 once pifo_count is 0.
  - Mid-operation reset drops any pending insert immediately.
- Deassertion of rst is synchronised externally; the first accept may occur on the first edge after release.

## Configuration
- STFQ_WEIGHT_EN defined:
  - A NUM_FLOWS×3-bit shift table is instantiated.
  - cfg_we writes cfg_shift to shift[cfg_flow] at the edge, visible to descriptors accepted the next cycle.
  - inc = pkt_len >> shift[pkt_flow].
- STFQ_WEIGHT_EN undefined:
  - No shift table; inc = pkt_len.
  - cfg_we, cfg_flow and cfg_shift remain as ports and are ignored.

## Test plan
- Reset, then flow 3 len 100 meta 0x0AB → next cycle insert=1, rank_out=0, meta_out=0x0AB; a second flow 3 len 50 → rank_out=100.
- Interleave flow 1 len 200 and flow 2 len 40 with vtime=0 → ranks 0, 0; repeat both → ranks 200, 40; then deq_valid deq_rank=150 → vtime=150, and next flow 2 len 10 → rank_out=150.
- Hold pifo_count=15 with one accept → pkt_ready=0 while insert=1; pifo_count=16 → pkt_ready=0; pifo_count drops to 15 with insert=0 → pkt_ready=1.
- Flow 0 len 2047 repeated 33 times → finish tag clamps at 65535, sat=1, subsequent ranks 65535; deq_rank 10 after vtime=500 → vtime stays 500.
- With STFQ_WEIGHT_EN: cfg shift[5]=2, then flow 5 len 400 twice → ranks 0, 100. Without the macro: ranks 0, 400.
- Assert rst during a cycle with insert=1 → insert=0 immediately; after release, flow 3 len 100 → rank_out=0.
